cache_stream_fifo: RTL and testbench
====================================

// Module: cache_stream_fifo
// PURPOSE
//  Parametrised valid/ready synchronous FIFO for cache request/refill/writeback queues.
//  Supports non-power-of-2 depth, an optional registered output stage and
//  programmable almost-full/almost-empty flags. A peak-occupancy watermark supports sizing.
//  Over/underflow is impossible by construction: pushes and pops happen only on handshake.
// PARAMETERS
//  DATA_WIDTH     32  payload width in bits
//  FIFO_DEPTH     16  storage entries, any value >= 2 (not restricted to a power of 2)
//  OUT_REG        1   1: out_data driven from a flop stage, which adds 1 capacity entry; 0: out_data read combinationally from storage
//  AFULL_THRESH   14  almost_full asserts when data_num >= AFULL_THRESH (1..CAP)
//  AEMPTY_THRESH  2   almost_empty asserts when data_num <= AEMPTY_THRESH (0..CAP-1)
//  Derived: CAP = FIFO_DEPTH + OUT_REG; CNT_W = $clog2(CAP+1)
// PORTS
//  clk           in   1           clock
//  rst_n         in   1           asynchronous active-low reset
//  soft_rst      in   1           synchronous flush; wins over all other inputs
//  in_valid      in   1           producer has data
//  in_ready      out  1           FIFO can accept; = (data_num < CAP)
//  in_data       in   DATA_WIDTH  write payload
//  out_valid     out  1           head entry valid; = (data_num != 0)
//  out_ready     in   1           consumer takes head
//  out_data      out  DATA_WIDTH  head payload, stable while out_valid && !out_ready
//  data_num      out  CNT_W       current occupancy, 0..CAP
//  almost_full   out  1           data_num >= AFULL_THRESH
//  almost_empty  out  1           data_num <= AEMPTY_THRESH
//  peak_num      out  CNT_W       maximum data_num seen since reset/soft_rst
// BEHAVIOUR
//  Reset (rst_n=0 or soft_rst=1 at edge):
//   - Pointers, count, peak_num and output-stage valid clear.
//   - Outputs after reset: in_ready=1, out_valid=0, data_num=0, almost_full=0, almost_empty=1, peak_num=0.
//   - out_data resets to 0 when OUT_REG=1.
//   - Storage contents are not reset.
//  Handshake:
//   - push = in_valid && in_ready; pop = out_valid && out_ready.
//   - in_ready does not depend on out_ready: when full, a same-cycle pop does not admit a push.
//  Pointers:
//   - Binary read/write pointers in 0..FIFO_DEPTH-1.
//   - Each pointer wraps to 0 after FIFO_DEPTH-1 (explicit compare, not modulo 2^N).
//  Occupancy:
//   - data_num is an explicit counter: +1 on push only, -1 on pop only, unchanged on both or neither.
//   - Flags and peak_num derive from the registered data_num.
//  Latency:
//   - A push at edge N gives out_valid=1 after edge N if the FIFO was empty, for both OUT_REG values.
//   - For OUT_REG=1 this uses a bypass: when the output stage is empty or is being popped, and storage is empty, in_data loads the output flop directly.
//  OUT_REG=1 output stage:
//   - Holds the head entry.
//   - On pop, refills from storage[rptr] (rptr advances) if storage is non-empty; otherwise from the bypass if push; otherwise goes invalid.
//   - Ordering is strictly FIFO in all cases.
//  Simultaneous push+pop:
//   - Empty: push only; pop impossible.
//   - Full: pop only.
//   - Otherwise both complete; data_num unchanged.
//  peak_num: peak_num <= max(peak_num, next data_num) every cycle; saturates at CAP.
//  Reset mid-operation: rst_n or soft_rst discards all entries immediately; any in-flight handshake in that cycle is dropped.
//  Assertions (ASSERT_ON):
//   - out_data stable while out_valid && !out_ready.
//   - data_num <= CAP.
//   - No push when !in_ready.
// TESTING
//  1. DEPTH=5, OUT_REG=1, CAP=6. Push 0xA0..0xA5 with out_ready=0 -> data_num=6, in_ready=0, almost_full=1; a 7th in_valid is not accepted.
//  2. From test 1, assert out_ready for 6 cycles -> out_data sequence 0xA0..0xA5, then out_valid=0, data_num=0, peak_num=6.
//  3. Empty FIFO, push 0x11 at edge N -> out_valid=1 and out_data=0x11 in cycle N+1 (both OUT_REG=0 and 1).
//  4. Continuous push+pop over 3*DEPTH beats with DEPTH=5 -> wrap covered, data_num constant at 1, output sequence matches input.
//  5. Full FIFO, in_valid=1 and out_ready=1 same cycle -> one pop, no push, data_num=CAP-1.
//  6. data_num=4, pulse soft_rst with in_valid=1 -> next cycle data_num=0, out_valid=0, peak_num=0, almost_empty=1.

Source files
------------

// File: rtl/cache_stream_fifo.sv
// cache_stream_fifo: valid/ready FIFO with optional registered output stage, occupancy flags and peak watermark
module cache_stream_fifo #(
   parameter  int DATA_WIDTH    = 32,
   parameter  int FIFO_DEPTH    = 16,
   parameter  int OUT_REG       = 1,
   parameter  int AFULL_THRESH  = 14,
   parameter  int AEMPTY_THRESH = 2,
   localparam int CAP           = FIFO_DEPTH + OUT_REG,
   localparam int CNT_W         = $clog2(CAP + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  soft_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]      data_num,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_W-1:0]      peak_num
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam bit OREG  = (OUT_REG != 0);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wptr, rptr;
   logic [CNT_W-1:0]      cnt_nxt, st_num;
   logic                  push, pop, bypass, wr_st, rd_st;

   // pointers wrap explicitly so any depth works, not just powers of two
   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_ready     = data_num < CNT_W'(CAP);
   assign out_valid    = data_num != '0;
   assign almost_full  = data_num >= CNT_W'(AFULL_THRESH);
   assign almost_empty = data_num <= CNT_W'(AEMPTY_THRESH);

   // handshakes, storage routing and next occupancy
   always_comb begin
      push    = in_valid && in_ready;
      pop     = out_valid && out_ready;
      st_num  = OREG ? data_num - CNT_W'(out_valid) : data_num;
      bypass  = OREG && push && (st_num == '0) && (!out_valid || pop);
      wr_st   = push && !bypass;
      rd_st   = OREG ? (pop && st_num != '0) : pop;
      cnt_nxt = (push && !pop) ? data_num + 1'b1 :
                (pop && !push) ? data_num - 1'b1 : data_num;
   end

   // pointers, occupancy counter and peak watermark
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         data_num <= '0;
         peak_num <= '0;
      end else if (soft_rst) begin
         wptr     <= '0;
         rptr     <= '0;
         data_num <= '0;
         peak_num <= '0;
      end else begin
         if (wr_st) wptr <= inc(wptr);
         if (rd_st) rptr <= inc(rptr);
         data_num <= cnt_nxt;
         peak_num <= (cnt_nxt > peak_num) ? cnt_nxt : peak_num;
      end
   end

   // storage array, intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_st && !soft_rst) mem[wptr] <= in_data;
   end

   if (OREG) begin : g_oreg
      logic [DATA_WIDTH-1:0] oreg;
      // output flop refills from storage, or straight from in_data when storage is empty
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) oreg <= '0;
         else if (soft_rst) oreg <= '0;
         else if (rd_st) oreg <= mem[rptr];
         else if (bypass) oreg <= in_data;
      end
      assign out_data = oreg;
   end else begin : g_comb
      assign out_data = mem[rptr];
   end

`ifdef ASSERT_ON
   a_stable : assert property (@(posedge clk) disable iff (!rst_n || soft_rst)
      out_valid && !out_ready |=> $stable(out_data));
   a_cap : assert property (@(posedge clk) disable iff (!rst_n)
      data_num <= CNT_W'(CAP));
   a_push : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !in_ready));
`endif
endmodule

// File: tb/tb_cache_stream_fifo.sv
// tb_cache_stream_fifo: directed checks of a registered-output and a combinational-output instance
module tb_cache_stream_fifo;
   localparam int DW = 8;
   logic          clk = 1'b0, rst_n = 1'b0, soft_rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready0, out_valid0, af0, ae0, in_ready1, out_valid1, af1, ae1;
   logic [DW-1:0] out_data0, out_data1;
   logic [2:0]    num0, peak0, num1, peak1;
   int            total = 0, bad = 0;
   logic [DW-1:0] exp_in, exp_out;

   always #5 clk = ~clk;

   cache_stream_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(5), .OUT_REG(0), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .data_num(num0), .almost_full(af0), .almost_empty(ae0), .peak_num(peak0));

   cache_stream_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(5), .OUT_REG(1), .AFULL_THRESH(5), .AEMPTY_THRESH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .data_num(num1), .almost_full(af1), .almost_empty(ae1), .peak_num(peak1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12 rst_n = 1'b1;
      chk("rst_ir0", in_ready0, 1);  chk("rst_ir1", in_ready1, 1);
      chk("rst_ov0", out_valid0, 0); chk("rst_ov1", out_valid1, 0);
      chk("rst_n0", num0, 0);        chk("rst_n1", num1, 0);
      chk("rst_af0", af0, 0);        chk("rst_af1", af1, 0);
      chk("rst_ae0", ae0, 1);        chk("rst_ae1", ae1, 1);
      chk("rst_pk0", peak0, 0);      chk("rst_pk1", peak1, 0);
      chk("rst_od1", out_data1, 0);
      // single push into empty FIFO appears the next cycle
      in_valid = 1'b1; in_data = 8'h11;
      tick();
      chk("lat_ov0", out_valid0, 1); chk("lat_ov1", out_valid1, 1);
      chk("lat_od0", out_data0, 8'h11); chk("lat_od1", out_data1, 8'h11);
      chk("lat_n0", num0, 1);        chk("lat_n1", num1, 1);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("lat_pop_ov0", out_valid0, 0); chk("lat_pop_ov1", out_valid1, 0);
      chk("lat_pop_n1", num1, 0);    chk("lat_pk1", peak1, 1);
      out_ready = 1'b0;
      // fill to capacity, then one rejected push
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
         chk("fill_ir0", in_ready0, (i < 5) ? 1 : 0);
         chk("fill_ir1", in_ready1, 1);
         tick();
      end
      chk("full_n0", num0, 5);   chk("full_n1", num1, 6);
      chk("full_ir0", in_ready0, 0); chk("full_ir1", in_ready1, 0);
      chk("full_af0", af0, 1);   chk("full_af1", af1, 1);
      chk("full_ae1", ae1, 0);   chk("full_od1", out_data1, 8'hA0);
      chk("full_od0", out_data0, 8'hA0);
      in_data = 8'hA6;
      tick();
      chk("rej_n0", num0, 5);    chk("rej_n1", num1, 6);
      chk("full_pk0", peak0, 5); chk("full_pk1", peak1, 6);
      in_valid = 1'b0;
      // drain in order
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("drn_ov1", out_valid1, 1);
         chk("drn_od1", out_data1, 8'hA0 + 8'(i));
         chk("drn_ov0", out_valid0, (i < 5) ? 1 : 0);
         if (i < 5) chk("drn_od0", out_data0, 8'hA0 + 8'(i));
         tick();
      end
      chk("drn_end_ov1", out_valid1, 0); chk("drn_end_n1", num1, 0);
      chk("drn_end_pk1", peak1, 6);      chk("drn_end_ae1", ae1, 1);
      chk("drn_end_n0", num0, 0);
      out_ready = 1'b0;
      // full with push and pop together: pop only
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 8'hB0 + 8'(i);
         tick();
      end
      in_data = 8'hC0; out_ready = 1'b1;
      tick();
      chk("fpp_n0", num0, 4);   chk("fpp_n1", num1, 5);
      chk("fpp_od0", out_data0, 8'hB1); chk("fpp_od1", out_data1, 8'hB1);
      chk("fpp_ir0", in_ready0, 1);     chk("fpp_af1", af1, 1);
      in_valid = 1'b0;
      tick();
      chk("pop_n1", num1, 4);   chk("pop_n0", num0, 3);
      chk("pop_od1", out_data1, 8'hB2); chk("pop_od0", out_data0, 8'hB2);
      // soft reset with a handshake in flight
      soft_rst = 1'b1; in_valid = 1'b1;
      tick();
      soft_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("srst_n1", num1, 0);        chk("srst_n0", num0, 0);
      chk("srst_ov1", out_valid1, 0); chk("srst_ov0", out_valid0, 0);
      chk("srst_pk1", peak1, 0);      chk("srst_pk0", peak0, 0);
      chk("srst_ae1", ae1, 1);        chk("srst_od1", out_data1, 0);
      // streaming push+pop across pointer wrap at occupancy 1 and 3
      exp_in = 8'hD0; exp_out = 8'hD0;
      for (int k = 1; k <= 3; k += 2) begin
         in_valid = 1'b1; out_ready = 1'b0;
         for (int j = 0; j < k; j++) begin
            in_data = exp_in; exp_in++;
            tick();
         end
         out_ready = 1'b1;
         for (int b = 0; b < 15; b++) begin
            in_data = exp_in; exp_in++;
            chk("str_n0", num0, k);  chk("str_n1", num1, k);
            chk("str_od0", out_data0, exp_out); chk("str_od1", out_data1, exp_out);
            exp_out++;
            tick();
         end
         in_valid = 1'b0;
         for (int j = 0; j < k; j++) begin
            chk("str_tail0", out_data0, exp_out); chk("str_tail1", out_data1, exp_out);
            exp_out++;
            tick();
         end
         chk("str_end_n0", num0, 0); chk("str_end_n1", num1, 0);
         chk("str_pk1", peak1, k);
      end
      out_ready = 1'b0;
      // asynchronous reset mid-operation
      in_valid = 1'b1; in_data = 8'hE0;
      tick();
      tick();
      in_valid = 1'b0;
      chk("pre_arst_n1", num1, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_n0", num0, 0);        chk("arst_n1", num1, 0);
      chk("arst_ov1", out_valid1, 0); chk("arst_od1", out_data1, 0);
      chk("arst_pk1", peak1, 0);
      rst_n = 1'b1;
      tick();
      chk("post_arst_ir1", in_ready1, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
